game_state_ctrl: RTL

GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

---
 rtl/game_state_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/game_state_ctrl.sv
// Game flow controller: title, play, pause, drop-out, game over and
// the hold-off state that waits for the keyboard to go idle.
module game_state_ctrl #(
    parameter int          KEY_SLOTS   = 2,
    parameter logic [7:0]  KEY_START   = 8'd40,
    parameter logic [7:0]  KEY_PAUSE   = 8'd44,
    parameter int          DROP_FRAMES = 50,
    parameter int          LIVES       = 3
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_clk,
    input  logic [8*KEY_SLOTS-1:0] keycode,
    input  logic                   death,
    input  logic                   drop,
    output logic [2:0]             show,
    output logic                   restart,
    output logic                   respawn,
    output logic [2:0]             lives_left,
    output logic [2:0]             state_o
);

    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_PLAY  = 3'd1,
        ST_PAUSE = 3'd2,
        ST_DROP  = 3'd3,
        ST_DEAD  = 3'd4,
        ST_HALT  = 3'd5
    } state_t;

    localparam logic [6:0] CNT_LAST   = 7'(DROP_FRAMES - 1);
    localparam logic [2:0] LIVES_INIT = 3'(LIVES);

    state_t     state, state_n;
    logic [2:0] lives_n;
    logic [6:0] drop_cnt, drop_cnt_n;
    logic       respawn_n;
    logic       lose_life;

    logic fsync1, fsync2, fsync3;
    logic tick;

    logic hit_start, hit_pause, key_idle;
    logic hit_start_q, hit_pause_q;
    logic press_start, press_pause;

    // frame_clk is foreign to Clk: two flops to settle, a third for the edge
    always_ff @(posedge Clk) begin
        if (Reset) begin
            fsync1 <= 1'b0;
            fsync2 <= 1'b0;
            fsync3 <= 1'b0;
        end else begin
            fsync1 <= frame_clk;
            fsync2 <= fsync1;
            fsync3 <= fsync2;
        end
    end

    assign tick = fsync2 & ~fsync3;

    always_comb begin
        hit_start = 1'b0;
        hit_pause = 1'b0;
        for (int i = 0; i < KEY_SLOTS; i++) begin
            if (keycode[8*i +: 8] == KEY_START) hit_start = 1'b1;
            if (keycode[8*i +: 8] == KEY_PAUSE) hit_pause = 1'b1;
        end
    end

    assign key_idle = (keycode == '0);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            hit_start_q <= 1'b0;
            hit_pause_q <= 1'b0;
        end else begin
            hit_start_q <= hit_start;
            hit_pause_q <= hit_pause;
        end
    end

    assign press_start = hit_start & ~hit_start_q;
    assign press_pause = hit_pause & ~hit_pause_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state      <= ST_START;
            lives_left <= LIVES_INIT;
            drop_cnt   <= 7'd0;
            respawn    <= 1'b0;
        end else begin
            state      <= state_n;
            lives_left <= lives_n;
            drop_cnt   <= drop_cnt_n;
            respawn    <= respawn_n;
        end
    end

    always_comb begin
        state_n    = state;
        lives_n    = lives_left;
        drop_cnt_n = drop_cnt;
        respawn_n  = 1'b0;
        lose_life  = 1'b0;
        case (state)
            ST_START: begin
                lives_n = LIVES_INIT;
                if (press_start) state_n = ST_PLAY;
            end
            ST_PLAY: begin
                if (death) begin
                    lose_life = 1'b1;
                end else if (drop) begin
                    state_n    = ST_DROP;
                    drop_cnt_n = 7'd0;
                end else if (press_pause) begin
                    state_n = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (press_pause || press_start) state_n = ST_PLAY;
            end
            ST_DROP: begin
                if (tick) begin
                    if (drop_cnt == CNT_LAST) lose_life = 1'b1;
                    else drop_cnt_n = drop_cnt + 7'd1;
                end
            end
            ST_DEAD: begin
                if (hit_start) state_n = ST_HALT;
            end
            ST_HALT: begin
                // reload here so lives read full on the first START cycle
                if (key_idle) begin
                    state_n = ST_START;
                    lives_n = LIVES_INIT;
                end
            end
            default: begin
                state_n = ST_START;
                lives_n = LIVES_INIT;
            end
        endcase
        if (lose_life) begin
            if (lives_left > 3'd1) begin
                lives_n   = lives_left - 3'd1;
                respawn_n = 1'b1;
                state_n   = ST_PLAY;
            end else begin
                lives_n = 3'd0;
                state_n = ST_DEAD;
            end
        end
    end

    always_comb begin
        show    = 3'd1;
        restart = 1'b0;
        case (state)
            ST_START: restart = 1'b1;
            ST_PLAY:  show    = 3'd0;
            ST_PAUSE: show    = 3'd2;
            ST_DROP:  show    = 3'd0;
            ST_DEAD:  show    = 3'd3;
            default:  show    = 3'd1;
        endcase
    end

    assign state_o = state;

endmodule
